// File: rtl/i2s_rx.sv
// I2S receiver for a single-slot microphone: generates the bit clock and word
// select, captures one channel MSB first, and offers each word on a valid/ready port.
module i2s_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int I2S_CLK_FREQ = 1_500_000,
    parameter int DATA_SIZE    = 24,
    parameter int CHANNEL      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 i2s_clk,
    output logic                 i2s_ws,
    input  logic                 i2s_sd,
    output logic [DATA_SIZE-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overflow,
    output logic [15:0]          drop_count
);

    localparam int HALF_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int DIV_W    = $clog2(HALF_DIV);
    localparam int SHIFT_W  = (DATA_SIZE > 1) ? DATA_SIZE - 1 : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [4:0]       LAST_SLOT = 5'(DATA_SIZE);
    localparam logic             CH_BIT    = 1'(CHANNEL);

    if (HALF_DIV < 4) begin : g_half_div_check
        $error("i2s_rx: HALF_DIV must be at least 4");
    end
    if (DATA_SIZE < 1 || DATA_SIZE > 31) begin : g_data_size_check
        $error("i2s_rx: DATA_SIZE must be within 1..31");
    end

    logic               sd_m;
    logic               sd_s;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [5:0]         bit_cnt_inc;
    logic [4:0]         slot;
    logic [SHIFT_W-1:0] shift;
    logic [DATA_SIZE-1:0] word;
    logic tick;
    logic rise_ev;
    logic fall_ev;
    logic capture;
    logic complete;
    logic xfer;

    assign slot        = bit_cnt[4:0];
    assign bit_cnt_inc = bit_cnt + 6'd1;
    assign tick        = enable && (div_cnt == DIV_LAST);
    assign rise_ev     = tick && !i2s_clk;
    assign fall_ev     = tick && i2s_clk;
    assign capture     = rise_ev && (bit_cnt[5] == CH_BIT) && (slot != 5'd0) && (slot <= LAST_SLOT);
    assign complete    = capture && (slot == LAST_SLOT);

    // Handshake: a word moves downstream in any cycle where sample_valid and
    // sample_ready are both high; sample_data is frozen while valid waits for ready.
    assign xfer = sample_valid && sample_ready;

    // The word presented on completion includes the bit being captured right now.
    if (DATA_SIZE > 1) begin : g_wide
        assign word = {shift, sd_s};
    end else begin : g_narrow
        assign word = sd_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sd_m <= 1'b0;
            sd_s <= 1'b0;
        end else begin
            sd_m <= i2s_sd;
            sd_s <= sd_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt <= '0;
            i2s_clk <= 1'b0;
            bit_cnt <= '0;
            i2s_ws  <= 1'b0;
            shift   <= '0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                i2s_clk <= ~i2s_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_ev) begin
                bit_cnt <= bit_cnt_inc;
                i2s_ws  <= bit_cnt_inc[5];
            end
            if (capture) begin
                shift <= word[SHIFT_W-1:0];
            end
        end
    end

    // A completed word loads when the holding register is empty or being
    // emptied this cycle; otherwise it is dropped and counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else if (complete && (!sample_valid || xfer)) begin
            sample_data  <= word;
            sample_valid <= 1'b1;
        end else if (complete) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (xfer) begin
            sample_valid <= 1'b0;
        end
    end

endmodule
